// File: rtl/line_engine.sv
// line_engine: Bresenham line rasteriser that sits between the CPU command port
// and the framebuffer write arbiter. It accepts one line command at a time and
// emits one framebuffer write per pixel, in order from (x0,y0) to (x1,y1).
// Pixels whose y lies below the framebuffer are stepped over without a write.
module line_engine #(
    parameter int PIXEL_WIDTH    = 1024,
    parameter int PIXEL_HEIGHT   = 768,
    parameter int X_BITS         = 10,
    parameter int Y_BITS         = 10,
    parameter int COLOR_BITS     = 1,
    parameter int MEM_ADDR_WIDTH = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [X_BITS-1:0]         x0,
    input  logic [Y_BITS-1:0]         y0,
    input  logic [X_BITS-1:0]         x1,
    input  logic [Y_BITS-1:0]         y1,
    input  logic [COLOR_BITS-1:0]     color,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    output logic                      busy,
    output logic                      wr_en,
    input  logic                      wr_ready,
    output logic [MEM_ADDR_WIDTH-1:0] wr_addr,
    output logic [COLOR_BITS-1:0]     wr_data
);

    // Error term width: |dx| and |dy| need max(X_BITS,Y_BITS) bits, and the
    // doubled, signed error needs two more bits plus one bit of headroom.
    localparam int ERR_W = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 3;

    // One extra bit so the height still fits when it equals 2**Y_BITS.
    localparam logic [Y_BITS:0] HEIGHT_L = (Y_BITS + 1)'(PIXEL_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2
    } state_t;

    state_t state_q;

    // Latched command.
    logic [X_BITS-1:0]     x0_q, x1_q;
    logic [Y_BITS-1:0]     y0_q, y1_q;
    logic [COLOR_BITS-1:0] color_q;

    // Bresenham state.
    logic signed [ERR_W-1:0] dx_q;
    logic signed [ERR_W-1:0] dy_q;
    logic signed [ERR_W-1:0] err_q;
    logic                    sx_neg_q;
    logic                    sy_neg_q;
    logic [X_BITS-1:0]       cur_x_q;
    logic [Y_BITS-1:0]       cur_y_q;

    // Registered outputs.
    logic                      cmd_ready_q;
    logic                      busy_q;
    logic                      wr_en_q;
    logic [MEM_ADDR_WIDTH-1:0] wr_addr_q;
    logic [COLOR_BITS-1:0]     wr_data_q;

    // Combinational setup and step values.
    logic signed [ERR_W-1:0] setup_dx_d;
    logic signed [ERR_W-1:0] setup_dy_abs;
    logic signed [ERR_W-1:0] setup_dy_d;
    logic signed [ERR_W-1:0] e2;
    logic                    step_x;
    logic                    step_y;
    logic signed [ERR_W-1:0] err_d;
    logic [X_BITS-1:0]       cur_x_d;
    logic [Y_BITS-1:0]       cur_y_d;
    logic                    retire;
    logic                    at_end;

    // Linear framebuffer address of a pixel, row-major with PIXEL_WIDTH stride.
    function automatic logic [MEM_ADDR_WIDTH-1:0] pix_addr(
        input logic [X_BITS-1:0] x,
        input logic [Y_BITS-1:0] y
    );
        return MEM_ADDR_WIDTH'(y) * MEM_ADDR_WIDTH'(PIXEL_WIDTH) + MEM_ADDR_WIDTH'(x);
    endfunction

    // A pixel is written only when its row exists in the framebuffer.
    function automatic logic in_frame(input logic [Y_BITS-1:0] y);
        return {1'b0, y} < HEIGHT_L;
    endfunction

    // Line deltas computed from the latched endpoints, consumed in SETUP.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        setup_dx_d   = '0;
        setup_dy_abs = '0;
        if (x1_q >= x0_q) setup_dx_d = ERR_W'(x1_q - x0_q);
        else              setup_dx_d = ERR_W'(x0_q - x1_q);
        if (y1_q >= y0_q) setup_dy_abs = ERR_W'(y1_q - y0_q);
        else              setup_dy_abs = ERR_W'(y0_q - y1_q);
        setup_dy_d = -setup_dy_abs;
    end

    // One Bresenham step from the current pixel; both decisions use the pre-step error.
    always_comb begin
        e2      = err_q <<< 1;
        step_x  = (e2 >= dy_q);
        step_y  = (e2 <= dx_q);
        err_d   = err_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (step_x) begin
            err_d   = err_d + dy_q;
            cur_x_d = sx_neg_q ? cur_x_q - X_BITS'(1) : cur_x_q + X_BITS'(1);
        end
        if (step_y) begin
            err_d   = err_d + dx_q;
            cur_y_d = sy_neg_q ? cur_y_q - Y_BITS'(1) : cur_y_q + Y_BITS'(1);
        end
    end

    // The presented pixel leaves when the arbiter takes it, or at once if clipped.
    always_comb begin
        retire = wr_en_q ? wr_ready : 1'b1;
        at_end = (cur_x_q == x1_q) && (cur_y_q == y1_q);
    end

    // Control FSM and datapath registers, including all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the whole datapath is cleared so a line cut short by reset leaves no stale pixel behind.
            state_q     <= S_IDLE;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            color_q     <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            sx_neg_q    <= 1'b0;
            sy_neg_q    <= 1'b0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        x0_q        <= x0;
                        y0_q        <= y0;
                        x1_q        <= x1;
                        y1_q        <= y1;
                        color_q     <= color;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    dx_q      <= setup_dx_d;
                    dy_q      <= setup_dy_d;
                    err_q     <= setup_dx_d + setup_dy_d;
                    sx_neg_q  <= !(x0_q < x1_q);
                    sy_neg_q  <= !(y0_q < y1_q);
                    cur_x_q   <= x0_q;
                    cur_y_q   <= y0_q;
                    wr_en_q   <= in_frame(y0_q);
                    wr_addr_q <= pix_addr(x0_q, y0_q);
                    wr_data_q <= color_q;
                    state_q   <= S_DRAW;
                end

                S_DRAW: begin
                    // Outputs stay frozen while a write is stalled by the arbiter.
                    if (retire) begin
                        if (at_end) begin
                            wr_en_q     <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            err_q     <= err_d;
                            cur_x_q   <= cur_x_d;
                            cur_y_q   <= cur_y_d;
                            wr_en_q   <= in_frame(cur_y_d);
                            wr_addr_q <= pix_addr(cur_x_d, cur_y_d);
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_line_engine.sv
// tb_line_engine: directed vectors for line_engine with hand-computed pixel
// addresses, cycle timing, backpressure, clipping and mid-line reset.
module tb_line_engine;

    localparam int PIXEL_WIDTH    = 1024;
    localparam int PIXEL_HEIGHT   = 768;
    localparam int X_BITS         = 10;
    localparam int Y_BITS         = 10;
    localparam int COLOR_BITS     = 8;
    localparam int MEM_ADDR_WIDTH = 20;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [X_BITS-1:0]         x0, x1;
    logic [Y_BITS-1:0]         y0, y1;
    logic [COLOR_BITS-1:0]     color;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      busy;
    logic                      wr_en;
    logic                      wr_ready;
    logic [MEM_ADDR_WIDTH-1:0] wr_addr;
    logic [COLOR_BITS-1:0]     wr_data;

    line_engine #(
        .PIXEL_WIDTH   (PIXEL_WIDTH),
        .PIXEL_HEIGHT  (PIXEL_HEIGHT),
        .X_BITS        (X_BITS),
        .Y_BITS        (Y_BITS),
        .COLOR_BITS    (COLOR_BITS),
        .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x0       (x0),
        .y0       (y0),
        .x1       (x1),
        .y1       (y1),
        .color    (color),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Results of the most recent run_line call.
    int got_addr[$];
    int got_data[$];
    int first_rel;
    int done_rel;
    int stall_hold;
    int busy_setup;
    int busy_done;

    task automatic check(input string tag, input int actual, input int expected);
        check_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // Issue one command (caller is #1 after an edge) and collect its writes.
    // Cycle numbering is relative to the accept edge: cycle 1 is SETUP.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int acol, input int stall_at, input int stall_len);
        int idx;
        int stalled;
        got_addr.delete();
        got_data.delete();
        first_rel  = -1;
        done_rel   = -1;
        stall_hold = 0;
        busy_setup = -1;
        busy_done  = -1;
        idx        = 0;
        stalled    = 0;
        x0 = X_BITS'(ax0); y0 = Y_BITS'(ay0);
        x1 = X_BITS'(ax1); y1 = Y_BITS'(ay1);
        color = COLOR_BITS'(acol);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble the inputs after the accept; the engine must ignore them.
        cmd_valid = 1'b0;
        x0 = '1; y0 = '1; x1 = '1; y1 = '1; color = 8'h3C;
        for (int rel = 1; rel <= 300; rel++) begin
            if (rel == 1) busy_setup = int'(busy);
            if (rel >= 2 && cmd_ready) begin
                done_rel  = rel;
                busy_done = int'(busy);
                break;
            end
            wr_ready = 1'b1;
            if (wr_en) begin
                if (first_rel < 0) first_rel = rel;
                if (idx == stall_at) stall_hold++;
                if (idx == stall_at && stalled < stall_len) begin
                    wr_ready = 1'b0;
                    stalled++;
                end else begin
                    got_addr.push_back(int'(wr_addr));
                    got_data.push_back(int'(wr_data));
                    idx++;
                end
            end
            @(posedge clk); #1;
        end
        wr_ready = 1'b1;
    endtask

    task automatic check_seq(input string tag, input int exp_a[$], input int exp_d);
        check({tag, "_count"}, got_addr.size(), exp_a.size());
        foreach (exp_a[i]) begin
            if (i < got_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_a[i]);
                check($sformatf("%s_data%0d", tag, i), got_data[i], exp_d);
            end
        end
    endtask

    initial begin
        int found;
        int stray;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        wr_ready  = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_wr_en",     int'(wr_en),     0);
        check("rst_busy",      int'(busy),      0);
        check("rst_wr_addr",   int'(wr_addr),   0);
        check("rst_wr_data",   int'(wr_data),   0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Horizontal line: timing reference.
        check("t1_ready_pre", int'(cmd_ready), 1);
        run_line(0, 0, 3, 0, 1, -1, 0);
        check_seq("t1", '{0, 1, 2, 3}, 1);
        check("t1_first_wr",   first_rel,  2);
        check("t1_ready_back", done_rel,   6);
        check("t1_busy_setup", busy_setup, 1);
        check("t1_busy_done",  busy_done,  0);

        // Steep line, forwards and reversed.
        run_line(0, 0, 1, 3, 1, -1, 0);
        check_seq("t2f", '{0, 1024, 2049, 3073}, 1);
        check("t2f_ready_back", done_rel, 6);
        run_line(1, 3, 0, 0, 1, -1, 0);
        check_seq("t2r", '{3073, 2049, 1024, 0}, 1);
        check("t2r_ready_back", done_rel, 6);

        // Reversed diagonal with a multi-bit colour.
        run_line(3, 3, 0, 0, 8'hA5, -1, 0);
        check_seq("t3", '{3075, 2050, 1025, 0}, 8'hA5);

        // Backpressure on the third pixel for three cycles.
        run_line(0, 0, 7, 0, 1, 2, 3);
        check_seq("t4", '{0, 1, 2, 3, 4, 5, 6, 7}, 1);
        check("t4_hold_cycles", stall_hold, 4);
        check("t4_ready_back",  done_rel,   13);

        // Vertical line crossing the bottom edge: last two pixels clipped.
        run_line(0, 766, 0, 769, 1, -1, 0);
        check_seq("t5", '{784384, 785408}, 1);
        check("t5_ready_back", done_rel,  6);
        check("t5_busy_done",  busy_done, 0);

        // Reset while pixel 3 of a long line is on the bus.
        x0 = 10'd0; y0 = 10'd0; x1 = 10'd9; y1 = 10'd0; color = 8'h01;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            if (wr_en && wr_addr == 20'd3) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("t6_reached_px3", found, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_wr_en_after_rst",     int'(wr_en),     0);
        check("t6_cmd_ready_after_rst", int'(cmd_ready), 1);
        check("t6_busy_after_rst",      int'(busy),      0);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (wr_en) stray++;
        end
        check("t6_no_stray_writes", stray, 0);
        run_line(5, 5, 5, 5, 1, -1, 0);
        check_seq("t6_point", '{5125}, 1);
        check("t6_point_ready_back", done_rel, 3);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
